// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types for the writeback stage
package pipeline_pkg;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef enum logic {WB_IDLE, WB_WAIT_LOAD} wb_state_t;
endpackage

// File: rtl/writeback_load_extract.sv
// load_extract: selects byte/half/word from a doubleword and extends it
module load_extract
  import pipeline_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] rdata,
  input  logic [2:0]   funct3,
  input  logic [2:0]   off,
  output logic [N-1:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[2:1], 4'b0000} +: 16];
  assign w = rdata[{off[2], 5'b00000} +: 32];
  assign value = funct3 == F3_LB  ? {{(N-8){b[7]}}, b} :
                 funct3 == F3_LH  ? {{(N-16){h[15]}}, h} :
                 funct3 == F3_LW  ? {{(N-32){w[31]}}, w} :
                 funct3 == F3_LD  ? rdata :
                 funct3 == F3_LBU ? {{(N-8){1'b0}}, b} :
                 funct3 == F3_LHU ? {{(N-16){1'b0}}, h} :
                 funct3 == F3_LWU ? {{(N-32){1'b0}}, w} : '0;
endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage; selects result, waits for load data, drives RF write port
module writeback
  import pipeline_pkg::*;
#(
  parameter int N        = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  output logic         ready_W,
  input  logic         regWrite_M,
  input  logic [1:0]   resultSrc_M,
  input  logic [2:0]   funct3_M,
  input  logic [4:0]   rd_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] pcPlus4_M,
  input  logic [N-1:0] memRdata,
  input  logic         memRvalid,
  output logic         regWrite_D,
  output logic [4:0]   wa3_D,
  output logic [N-1:0] writeData3_D,
  output logic         loadTimeout_W,
  output logic [63:0]  instret_W
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  wb_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic          pend_we;
  logic [4:0]    pend_rd;
  logic [2:0]    pend_f3, pend_off;
  logic          accept, is_load, waiting, start_wait, timeout, retire, wr_we, do_write;
  logic [4:0]    wr_rd;
  logic [N-1:0]  ext, wr_data;
  load_extract #(.N(N)) u_ext (
    .rdata (memRdata),
    .funct3(waiting ? pend_f3 : funct3_M),
    .off   (waiting ? pend_off : aluResult_M[2:0]),
    .value (ext)
  );
  always_ff @(posedge clk)
    if (!reset) state <= WB_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == WB_IDLE ? (start_wait ? WB_WAIT_LOAD : WB_IDLE)
                               : (memRvalid || timeout ? WB_IDLE : WB_WAIT_LOAD);
  always_comb begin
    ready_W    = state == WB_IDLE;
    waiting    = state == WB_WAIT_LOAD;
    accept     = valid_M && ready_W;
    is_load    = resultSrc_M == RES_MEM;
    start_wait = accept && is_load && !memRvalid;
    timeout    = waiting && !memRvalid && cnt == CW'(MAX_WAIT - 1);
    retire     = (accept && (!is_load || memRvalid)) || (waiting && memRvalid);
    wr_we      = waiting ? pend_we : regWrite_M;
    wr_rd      = waiting ? pend_rd : rd_M;
    do_write   = retire && wr_we && wr_rd != 5'd0;
    wr_data    = waiting || is_load ? ext : resultSrc_M == RES_PC4 ? pcPlus4_M : aluResult_M;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      regWrite_D    <= 1'b0;
      wa3_D         <= '0;
      writeData3_D  <= '0;
      loadTimeout_W <= 1'b0;
      instret_W     <= '0;
      cnt           <= '0;
      pend_we       <= 1'b0;
      pend_rd       <= '0;
      pend_f3       <= '0;
      pend_off      <= '0;
    end else begin
      regWrite_D <= do_write;
      if (do_write) begin
        wa3_D        <= wr_rd;
        writeData3_D <= wr_data;
      end
      if (retire) instret_W <= instret_W + 64'd1;
      if (timeout) loadTimeout_W <= 1'b1;
      if (start_wait) begin
        cnt      <= '0;
        pend_we  <= regWrite_M;
        pend_rd  <= rd_M;
        pend_f3  <= funct3_M;
        pend_off <= aluResult_M[2:0];
      end else if (waiting && !memRvalid) cnt <= cnt + 1'b1;
    end
  end
endmodule
